// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//   Start/done request bundle for serial_subtractor.
//   Configuration macro: SERSUB_OVF_EN (adds the signed-overflow flag).
//
//   Signals
//     start   master->slave  operation request
//     a, b    master->slave  minuend / subtrahend, WIDTH bits
//     b_in    master->slave  borrow-in
//     busy    slave->master  1 while the digit loop is running
//     done    slave->master  1-cycle completion pulse
//     diff    slave->master  result, WIDTH bits, held until next completion
//     b_out   slave->master  final borrow, held with diff
//     ovf     slave->master  signed overflow (SERSUB_OVF_EN only)
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
`ifdef SERSUB_OVF_EN
  logic             ovf;
`endif

  // Requester side
  modport master (
    output start, a, b, b_in,
`ifdef SERSUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, b_out
  );

  // Subtractor side
  modport slave (
    input  start, a, b, b_in,
`ifdef SERSUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, b_out
  );

endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Multi-cycle subtractor: diff = a - b - b_in (mod 2^WIDTH), b_out = final
//   borrow. DIGIT bits are subtracted per clock by one digit slice feeding a
//   borrow flop, so an operation takes STEPS = WIDTH/DIGIT cycles in RUN.
//   Start/done handshake, intended to sit under a controlling FSM.
//
//   Configuration macro: SERSUB_OVF_EN
//     defined   -> bus.ovf present, signed overflow registered with diff
//     undefined -> no ovf port and no MSB-borrow logic
//
//   Ports
//     clk   in   rising-edge clock
//     rst   in   asynchronous, active-high reset
//     bus   serial_subtractor_if.slave
//           start/a/b/b_in in; busy/done/diff/b_out(/ovf) out, all registered
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned STEPS   = WIDTH / DIGIT;
  localparam int unsigned CNT_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned SLICE_W = DIGIT + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  // Elaboration-time parameter legality
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be >= 2");
  end
  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  res_q;
  logic              borrow_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  diff_q;
  logic              b_out_q;

  logic              load_c;
  logic              step_c;
  logic              last_c;

  logic [DIGIT-1:0]  a_dig_c;
  logic [DIGIT-1:0]  b_dig_c;
  logic [DIGIT-1:0]  d_c;
  logic              bo_c;
  logic [WIDTH-1:0]  res_next_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    last_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here
        step_c = 1'b1;
        if (cnt_q == CNT_LAST) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Digit slice: the top bit of the (DIGIT+1)-bit difference is the borrow out
  assign a_dig_c = a_q[DIGIT-1:0];
  assign b_dig_c = b_q[DIGIT-1:0];
  assign {bo_c, d_c} = {1'b0, a_dig_c} - {1'b0, b_dig_c} - SLICE_W'(borrow_q);

  // Result digits enter at the top so the first digit ends up at bit 0
  assign res_next_c = (res_q >> DIGIT) | (WIDTH'(d_c) << (WIDTH - DIGIT));

  // Operand shifters, borrow, step counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= last_c;
      if (load_c) begin
        a_q      <= bus.a;
        b_q      <= bus.b;
        borrow_q <= bus.b_in;
        res_q    <= '0;
        cnt_q    <= '0;
      end else if (step_c) begin
        a_q      <= a_q >> DIGIT;
        b_q      <= b_q >> DIGIT;
        borrow_q <= bo_c;
        res_q    <= res_next_c;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (last_c) begin
        diff_q  <= res_next_c;
        b_out_q <= bo_c;
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.b_out = b_out_q;

`ifdef SERSUB_OVF_EN
  logic msb_bin_c;
  logic ovf_q;

  // Borrow into the MSB recovered from the MSB sum bit: d = a ^ b ^ borrow_in
  assign msb_bin_c = a_dig_c[DIGIT-1] ^ b_dig_c[DIGIT-1] ^ d_c[DIGIT-1];

  // Signed overflow: borrow into MSB differs from borrow out of MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (last_c) begin
      ovf_q <= msb_bin_c ^ bo_c;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor: an 8-bit/1-bit-digit instance
//   and a 16-bit/4-bit-digit instance share clock and reset. Expected results
//   come from an integer model and are queued when an operation is started,
//   then popped when done is seen.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        b_out;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus();
  serial_subtractor_if #(.WIDTH(16)) bus16();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  // Integer reference: unsigned difference, borrow, signed overflow
  function automatic exp_t model(input int w, input logic [15:0] a,
                                 input logic [15:0] b, input logic bin);
    exp_t e;
    int   t, sa, sbv, st, half;
    half    = 1 << (w - 1);
    t       = int'(a) - int'(b) - int'(bin);
    e.diff  = 16'(t & ((1 << w) - 1));
    e.b_out = (t < 0);
    sa      = (int'(a) >= half) ? int'(a) - 2 * half : int'(a);
    sbv     = (int'(b) >= half) ? int'(b) - 2 * half : int'(b);
    st      = sa - sbv - int'(bin);
    e.ovf   = (st < -half) || (st > half - 1);
    return e;
  endfunction

  // Single-cycle start pulse; returns just after the capture edge
  task automatic drive_start(input bit sel, input logic [15:0] a,
                             input logic [15:0] b, input logic bin);
    @(posedge clk); #1;
    if (sel) begin
      bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.b_in = bin;
      sb.push_back(model(16, a, b, bin));
    end else begin
      bus.start = 1'b1; bus.a = a[7:0]; bus.b = b[7:0]; bus.b_in = bin;
      sb.push_back(model(8, {8'h00, a[7:0]}, {8'h00, b[7:0]}, bin));
    end
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus16.start = 1'b0;
  endtask

  // Counts falling edges until done is seen; n-1 = clock edges after capture
  task automatic wait_done(input bit sel, input int budget, output int n,
                           output int busy_n, output bit to);
    n = 0; busy_n = 0; to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (sel ? bus16.busy : bus.busy) busy_n++;
      if (sel ? bus16.done : bus.done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    checks++;
    if (bus.diff !== 8'h00 || bus.b_out !== 1'b0) begin
      errors++; $display("FAIL reset_result diff=%h b_out=%b want 00/0", bus.diff, bus.b_out);
    end
    checks++;
    if (bus16.diff !== 16'h0000 || bus16.busy !== 1'b0) begin
      errors++; $display("FAIL reset_16 diff=%h busy=%b want 0000/0", bus16.diff, bus16.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n, bn; bit to; exp_t e;
    drive_start(1'b0, 16'h05, 16'h03, 1'b0);
    wait_done(1'b0, 40, n, bn, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout no done within 40 cycles"); end
    checks++;
    if (n - 1 !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", n - 1); end
    checks++;
    if (bn !== 8) begin errors++; $display("FAIL basic_busy got %0d cycles want 8", bn); end
    e = sb.pop_front();
    checks++;
    if (bus.diff !== e.diff[7:0] || bus.b_out !== e.b_out) begin
      errors++; $display("FAIL basic_result diff=%h b_out=%b want %h/%b", bus.diff, bus.b_out, e.diff[7:0], e.b_out);
    end
`ifdef SERSUB_OVF_EN
    checks++;
    if (bus.ovf !== e.ovf) begin errors++; $display("FAIL basic_ovf got %b want %b", bus.ovf, e.ovf); end
`endif
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.diff !== 8'h02) begin
      errors++; $display("FAIL basic_hold done=%b diff=%h want 0/02", bus.done, bus.diff);
    end
  endtask

  task automatic test_borrow_cases();
    int n, bn; bit to; exp_t e;
    logic [7:0] av[6] = '{8'h00, 8'h10, 8'h80, 8'hFF, 8'h00, 8'h7F};
    logic [7:0] bv[6] = '{8'h01, 8'h10, 8'h01, 8'h00, 8'hFF, 8'hFF};
    logic       cv[6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_start(1'b0, {8'h00, av[i]}, {8'h00, bv[i]}, cv[i]);
      wait_done(1'b0, 40, n, bn, to);
      e = sb.pop_front();
      checks++;
      if (to || bus.diff !== e.diff[7:0] || bus.b_out !== e.b_out) begin
        errors++;
        $display("FAIL borrow_case%0d to=%b diff=%h b_out=%b want %h/%b", i, to, bus.diff, bus.b_out, e.diff[7:0], e.b_out);
      end
`ifdef SERSUB_OVF_EN
      checks++;
      if (bus.ovf !== e.ovf) begin errors++; $display("FAIL ovf_case%0d got %b want %b", i, bus.ovf, e.ovf); end
`endif
    end
  endtask

  task automatic test_random();
    int n, bn; bit to; exp_t e;
    logic [7:0] ra, rb; logic rc;
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      drive_start(1'b0, {8'h00, ra}, {8'h00, rb}, rc);
      wait_done(1'b0, 40, n, bn, to);
      e = sb.pop_front();
      checks++;
      if (to || bus.diff !== e.diff[7:0] || bus.b_out !== e.b_out) begin
        errors++;
        $display("FAIL random%0d %h-%h-%b diff=%h b_out=%b want %h/%b", i, ra, rb, rc, bus.diff, bus.b_out, e.diff[7:0], e.b_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, bn; bit to; exp_t e; time t1, t2;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11; bus.b_in = 1'b0;
    sb.push_back(model(8, 16'h0033, 16'h0011, 1'b0));
    @(posedge clk); #1;
    // start stays high; operands for the second op may change during RUN
    bus.a = 8'h20; bus.b = 8'h21; bus.b_in = 1'b1;
    sb.push_back(model(8, 16'h0020, 16'h0021, 1'b1));
    wait_done(1'b0, 40, n, bn, to);
    t1 = $time;
    e = sb.pop_front();
    checks++;
    if (to || bus.diff !== e.diff[7:0] || bus.b_out !== e.b_out) begin
      errors++; $display("FAIL b2b_first to=%b diff=%h b_out=%b want %h/%b", to, bus.diff, bus.b_out, e.diff[7:0], e.b_out);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(1'b0, 40, n, bn, to);
    t2 = $time;
    e = sb.pop_front();
    checks++;
    if (to || bus.diff !== e.diff[7:0] || bus.b_out !== e.b_out) begin
      errors++; $display("FAIL b2b_second to=%b diff=%h b_out=%b want %h/%b", to, bus.diff, bus.b_out, e.diff[7:0], e.b_out);
    end
    checks++;
    if (t2 - t1 !== 90) begin errors++; $display("FAIL b2b_spacing got %0t want 90", t2 - t1); end
  endtask

  task automatic test_start_ignored();
    int n, bn, extra; bit to; exp_t e;
    drive_start(1'b0, 16'h0040, 16'h0015, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h01; bus.b_in = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(1'b0, 40, n, bn, to);
    e = sb.pop_front();
    checks++;
    if (to || bus.diff !== e.diff[7:0] || bus.b_out !== e.b_out) begin
      errors++; $display("FAIL ignore_result to=%b diff=%h b_out=%b want %h/%b", to, bus.diff, bus.b_out, e.diff[7:0], e.b_out);
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL ignore_no_second_op activity=%0d want 0", extra); end
  endtask

  task automatic test_reset_mid_run();
    int n, bn; bit to; exp_t e;
    drive_start(1'b0, 16'h0077, 16'h0011, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 8'h00) begin
      errors++; $display("FAIL midrst_clear busy=%b done=%b diff=%h want 0/0/00", bus.busy, bus.done, bus.diff);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    drive_start(1'b0, 16'h0009, 16'h0004, 1'b0);
    wait_done(1'b0, 40, n, bn, to);
    e = sb.pop_front();
    checks++;
    if (to || bus.diff !== 8'h05 || bus.diff !== e.diff[7:0] || bus.b_out !== 1'b0) begin
      errors++; $display("FAIL midrst_next to=%b diff=%h b_out=%b want 05/0", to, bus.diff, bus.b_out);
    end
  endtask

  task automatic test_wide_digit();
    int n, bn; bit to; exp_t e;
    drive_start(1'b1, 16'h1234, 16'h0235, 1'b1);
    wait_done(1'b1, 40, n, bn, to);
    checks++;
    if (to || n - 1 !== 4) begin errors++; $display("FAIL w16_latency to=%b got %0d want 4", to, n - 1); end
    e = sb.pop_front();
    checks++;
    if (bus16.diff !== e.diff || bus16.b_out !== e.b_out) begin
      errors++; $display("FAIL w16_result diff=%h b_out=%b want %h/%b", bus16.diff, bus16.b_out, e.diff, e.b_out);
    end
    drive_start(1'b1, 16'h0000, 16'hFFFF, 1'b1);
    wait_done(1'b1, 40, n, bn, to);
    e = sb.pop_front();
    checks++;
    if (to || bus16.diff !== e.diff || bus16.b_out !== e.b_out) begin
      errors++; $display("FAIL w16_wrap to=%b diff=%h b_out=%b want %h/%b", to, bus16.diff, bus16.b_out, e.diff, e.b_out);
    end
`ifdef SERSUB_OVF_EN
    checks++;
    if (bus16.ovf !== e.ovf) begin errors++; $display("FAIL w16_ovf got %b want %b", bus16.ovf, e.ovf); end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_borrow_cases();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_wide_digit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
